// File: rtl/rpsc_pkg.sv
// Shared constants, TX state encoding and helpers for the RPSC latch status reporter.
package rpsc_pkg;

    localparam int NUM_FLAGS    = 7;
    localparam int FRAME_BITS   = 14;
    localparam int PAYLOAD_BITS = FRAME_BITS - 2;

    localparam int FF33_IDX = 0;
    localparam int FF34_IDX = 1;
    localparam int FF35_IDX = 2;
    localparam int FF36_IDX = 3;
    localparam int FF37_IDX = 4;
    localparam int FF38_IDX = 5;
    localparam int FF39_IDX = 6;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Lowest set bit wins when several flags rise together.
    function automatic logic [2:0] lowest_index(input logic [NUM_FLAGS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rpsc_uart_tx_frame.sv
// Serialiser: start bit, 12 payload bits LSB first, stop bit; each bit BAUD_DIV clocks.
module rpsc_uart_tx_frame
    import rpsc_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [PAYLOAD_BITS-1:0] payload,
    output logic                    tx,
    output logic                    busy
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    tx_state_t               state_q, state_d;
    logic [BW-1:0]           baud_q, baud_d;
    logic [3:0]              bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    baud_end;

    assign baud_end = (baud_q == BW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The line level is registered so it only ever moves on a bit boundary.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    shift_d = payload;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 4'(PAYLOAD_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: rtl/rpsc_latch_status_tx.sv
// Synchronises the RPSC latch flags, records the first fault, drives the clear pulse
// and reports status frames on change, on clear and on a heartbeat.
module rpsc_latch_status_tx
    import rpsc_pkg::*;
#(
    parameter int BAUD_DIV  = 868,
    parameter int HEARTBEAT = 10_000_000,
    parameter int CLR_PULSE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_FLAGS-1:0] i_la,
    input  logic                 i_ack_clr,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_first_valid,
    output logic [2:0]           o_first_fault,
    output logic                 o_clr_req
);

    localparam int HB_W  = (HEARTBEAT > 2) ? $clog2(HEARTBEAT) : 1;
    localparam int CLR_W = $clog2(CLR_PULSE + 1);

    logic [NUM_FLAGS-1:0]    la_m, la_s, la_q;
    logic [NUM_FLAGS-1:0]    rises;
    logic                    change;
    logic                    first_valid;
    logic [2:0]              first_fault;
    logic                    clr_req;
    logic [CLR_W-1:0]        clr_cnt;
    logic                    clr_end;
    logic [HB_W-1:0]         hb_cnt;
    logic                    hb_wrap;
    logic                    pending;
    logic                    load;
    logic                    tx_busy;
    logic [PAYLOAD_BITS-1:0] payload;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            la_m <= '0;
            la_s <= '0;
            la_q <= '0;
        end else begin
            la_m <= i_la;
            la_s <= la_m;
            la_q <= la_s;
        end
    end

    assign rises  = la_s & ~la_q;
    assign change = |(la_s ^ la_q);

    // An acknowledge outranks a rise landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_valid <= 1'b0;
            first_fault <= '0;
        end else if (i_ack_clr) begin
            first_valid <= 1'b0;
            first_fault <= '0;
        end else if (!first_valid && (|rises)) begin
            first_valid <= 1'b1;
            first_fault <= lowest_index(rises);
        end
    end

    assign clr_end = clr_req && !i_ack_clr && (clr_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_req <= 1'b0;
            clr_cnt <= '0;
        end else if (i_ack_clr) begin
            clr_req <= 1'b1;
            clr_cnt <= CLR_W'(CLR_PULSE - 1);
        end else if (clr_req) begin
            if (clr_cnt == '0) clr_req <= 1'b0;
            else               clr_cnt <= clr_cnt - 1'b1;
        end
    end

    assign hb_wrap = !change && (hb_cnt == HB_W'(HEARTBEAT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                hb_cnt <= '0;
        else if (change || hb_wrap) hb_cnt <= '0;
        else                       hb_cnt <= hb_cnt + 1'b1;
    end

    // Events arriving while a frame is on the line collapse into one follow-up frame.
    assign load = pending && !tx_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= 1'b0;
        else        pending <= (pending && !load) || change || hb_wrap || clr_end;
    end

    assign payload = {^{first_valid, first_fault, la_s}, first_valid, first_fault, la_s};

    rpsc_uart_tx_frame #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .payload(payload),
        .tx     (o_tx),
        .busy   (tx_busy)
    );

    assign o_tx_busy     = tx_busy;
    assign o_first_valid = first_valid;
    assign o_first_fault = first_fault;
    assign o_clr_req     = clr_req;

endmodule
